// File: rtl/load_store_unit_if.sv
// Core-side request/response bus and data-memory port of the load/store unit.
interface load_store_unit_if #(
    parameter int unsigned MEM_AW = 10,
    parameter int unsigned XLEN   = 32
);
    // core request
    logic              req;
    logic              we;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    // core response
    logic              ready;
    logic              done;
    logic              err;
    logic [XLEN-1:0]   rdata;
    // data memory
    logic [MEM_AW-1:0] mem_A;
    logic [XLEN-1:0]   mem_WD;
    logic              mem_WE;
    logic [XLEN-1:0]   mem_RD;

    // core/memory environment side
    modport master (
        output req, we, funct3, addr, wdata, mem_RD,
        input  ready, done, err, rdata, mem_A, mem_WD, mem_WE
    );

    // load/store unit side
    modport slave (
        input  req, we, funct3, addr, wdata, mem_RD,
        output ready, done, err, rdata, mem_A, mem_WD, mem_WE
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed B/H/W loads and stores into word
// accesses on a 2^MEM_AW x XLEN memory; sub-word stores are read-modify-write.
// Optional macro LSU_RANGE_CHECK_EN rejects addresses beyond the memory size;
// without it the upper address bits are ignored and addresses wrap.
module load_store_unit #(
    parameter int unsigned MEM_AW = 10,
    parameter int unsigned XLEN   = 32
) (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.slave   bus
);
    localparam int unsigned AW = MEM_AW + 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MERGE = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [AW-1:0]   addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] merge_q;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;

    logic            accept_c;
    logic            reject_c;
    logic            invalid_c;
    logic            misalign_c;
    logic            range_c;
    logic [4:0]      shamt_c;
    logic [XLEN-1:0] lane_c;
    logic [XLEN-1:0] load_c;
    logic [XLEN-1:0] mask_c;
    logic [XLEN-1:0] merge_c;

`ifndef LSU_RANGE_CHECK_EN
    // upper address bits deliberately ignored: addresses wrap
    logic            unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[XLEN-1:AW];
`endif

    // legality of the request presented in IDLE
    always_comb begin
        invalid_c  = 1'b0;
        misalign_c = 1'b0;
        range_c    = 1'b0;
        if (bus.we) begin
            invalid_c = !(bus.funct3 inside {3'b000, 3'b001, 3'b010});
        end else begin
            invalid_c = bus.funct3 inside {3'b011, 3'b110, 3'b111};
        end
        misalign_c = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                     ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
`ifdef LSU_RANGE_CHECK_EN
        range_c = (bus.addr[XLEN-1:AW] != '0);
`endif
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state decode and request acceptance
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        reject_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    accept_c = 1'b1;
                    if (invalid_c || misalign_c || range_c) begin
                        reject_c = 1'b1;
                        state_d  = S_DONE;
                    end else if (!bus.we) begin
                        state_d = S_LOAD;
                    end else if (bus.funct3[1:0] == 2'b10) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_MERGE;
                    end
                end
            end
            S_LOAD:  state_d = S_DONE;
            S_MERGE: state_d = S_WRITE;
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // lane extraction/extension for loads and lane replacement for stores
    always_comb begin
        shamt_c = {addr_q[1:0], 3'b000};
        lane_c  = bus.mem_RD >> shamt_c;
        case (funct3_q)
            3'b000:  load_c = {{(XLEN-8){lane_c[7]}}, lane_c[7:0]};
            3'b100:  load_c = {{(XLEN-8){1'b0}}, lane_c[7:0]};
            3'b001:  load_c = {{(XLEN-16){lane_c[15]}}, lane_c[15:0]};
            3'b101:  load_c = {{(XLEN-16){1'b0}}, lane_c[15:0]};
            default: load_c = bus.mem_RD;
        endcase
        if (funct3_q[1:0] == 2'b00) begin
            mask_c = XLEN'(8'hFF) << shamt_c;
        end else begin
            mask_c = XLEN'(16'hFFFF) << shamt_c;
        end
        merge_c = (bus.mem_RD & ~mask_c) | ((XLEN'(wdata_q[15:0]) << shamt_c) & mask_c);
    end

    // request latches, merged store word and load result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            err_q    <= 1'b0;
            merge_q  <= '0;
            rdata_q  <= '0;
        end else begin
            if (accept_c) begin
                addr_q   <= bus.addr[AW-1:0];
                wdata_q  <= bus.wdata;
                funct3_q <= bus.funct3;
                err_q    <= reject_c;
            end
            if (state_q == S_LOAD) begin
                rdata_q <= load_c;
            end
            if (state_q == S_MERGE) begin
                merge_q <= merge_c;
            end
        end
    end

    // outputs decoded from the state register and latched request
    assign bus.ready  = (state_q == S_IDLE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.err    = (state_q == S_DONE) && err_q;
    assign bus.rdata  = rdata_q;
    assign bus.mem_A  = addr_q[AW-1:2];
    assign bus.mem_WE = (state_q == S_WRITE);
    assign bus.mem_WD = (funct3_q[1:0] == 2'b10) ? wdata_q : merge_q;

endmodule
